// File: rtl/corr_event_collector.sv
// Timestamps correlator rising edges, stages one per channel, queues them in a FIFO popped by DATA reads.
// Edge to FIFO in 2 cycles; a full FIFO holds events in staging, and only a re-edge on a staged channel loses one.
module corr_event_collector #(
  parameter logic [31:0] BASE  = 32'hFE000800,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic        PushADC,
  input  logic [7:0]  CorrelationSeen,
  output logic        EventIrq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PEND = BASE + 32'h04;
  localparam logic [31:0] A_STAT = BASE + 32'h08;
  localparam logic [31:0] A_DATA = BASE + 32'h0C;
  localparam logic [31:0] A_TS   = BASE + 32'h10;

  logic          en;
  logic [7:0]    mask;
  logic [7:0]    pend;
  logic          ovf;
  logic [27:0]   tstamp;
  logic [7:0]    seen_d;
  logic [7:0]    stage_v;
  logic [27:0]   stage_ts [8];
  logic [30:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic       wr_ctrl, wr_pend, wr_stat, wr_ts;
  logic       empty, full, push, pop;
  logic [7:0] rise, accept, drop, gnt_oh;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic       unused_wdata;

  assign unused_wdata = ^Wdata[31:28];

  assign wr_ctrl = write && (addr == A_CTRL);
  assign wr_pend = write && (addr == A_PEND);
  assign wr_stat = write && (addr == A_STAT);
  assign wr_ts   = write && (addr == A_TS);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = read && (addr == A_DATA) && !empty;

  assign rise   = CorrelationSeen & ~seen_d & mask & {8{en}};
  assign accept = rise & ~stage_v;
  // A channel still holding an un-queued event cannot take another one.
  assign drop   = rise & stage_v;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (stage_v[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(i);
      end
    end
    push   = gnt_vld && (!full || pop);
    gnt_oh = push ? (8'b1 << gnt_idx) : 8'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      mask    <= '0;
      pend    <= '0;
      ovf     <= 1'b0;
      tstamp  <= '0;
      seen_d  <= '0;
      stage_v <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= Wdata[0];
        mask <= Wdata[15:8];
      end
      pend <= (wr_pend ? (pend & ~Wdata[7:0]) : pend) | accept;
      ovf  <= (ovf & ~(wr_stat & Wdata[10])) | (|drop);
      if (wr_ts) begin
        tstamp <= Wdata[27:0];
      end else if (PushADC && en) begin
        tstamp <= tstamp + 28'd1;
      end
      seen_d  <= CorrelationSeen;
      stage_v <= (stage_v & ~gnt_oh) | accept;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: stage_v and count qualify every use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (accept[i]) stage_ts[i] <= tstamp;
    end
    if (push) mem[wr_ptr] <= {gnt_idx, stage_ts[gnt_idx]};
  end

  always_comb begin
    Rdata = '0;
    if (read) begin
      case (addr)
        A_CTRL:  Rdata = {16'h0, mask, 7'h0, en};
        A_PEND:  Rdata = {24'h0, pend};
        A_STAT:  Rdata = {21'h0, ovf, full, empty, 4'h0, 4'(count)};
        A_DATA:  Rdata = empty ? 32'h0 : {1'b1, mem[rd_ptr]};
        A_TS:    Rdata = {4'h0, tstamp};
        default: Rdata = '0;
      endcase
    end
  end

  assign EventIrq = en & (!empty | ovf);

endmodule

// File: doc/corr_event_collector.md
# corr_event_collector

Collects correlation-complete events from the eight correlator channels (the `CorrelationSeen0x` outputs of correlator blocks 00–07) and timestamps each event with a local sample counter. Events are queued in an 8-entry FIFO, which the host reads over the shared `addr`/`Wdata`/`Rdata` register bus. The block drives a single interrupt line, so the host services correlators from one pop register instead of polling each channel's status register.

## Interface
Parameters:
- `BASE`, 32'hFE000800: register block base address.
- `DEPTH`, 8: FIFO entries; fixed power of two.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `addr`  in  32: register bus address.
- `Wdata`  in  32: register bus write data.
- `write`  in  1: write strobe, one cycle per access.
- `read`  in  1: read strobe, one cycle per access.
- `Rdata`  out  32: combinational read data. Reset value 0.
- `PushADC`  in  1: sample strobe, shared with the correlators.
- `CorrelationSeen`  in  8: bit i is `CorrelationSeen0i` of channel i. It is a level signal that stays high until that channel's status register is read.
- `EventIrq`  out  1: interrupt. Reset value 0.

## Operation
Registers, at offsets from `BASE`:
- +0x00 `CTRL`, RW:
  - bit0 `en`.
  - bits[15:8] `mask`, per-channel enable.
  - Other bits read 0.
- +0x04 `PEND`, RW1C: sticky per-channel bit[7:0], set on each accepted edge.
- +0x08 `STAT`, RO except bit10:
  - [3:0] `count` (0–8).
  - bit8 `empty`.
  - bit9 `full`.
  - bit10 `ovf`, sticky. Writing 1 to bit10 clears it.
- +0x0C `DATA`, RO, pop-on-read:
  - bit31 = 1 (valid).
  - [30:28] channel number.
  - [27:0] timestamp.
  - An empty read returns 0 and does not pop.
- +0x10 `TSTAMP`, RW: 28-bit sample counter; [31:28] read 0.

Unmapped address, or `read`=0: `Rdata`=0.

Behaviour:
- **Timestamp counter.** Increments by 1 on each cycle with `PushADC`=1 and `en`=1. Wraps from 0xFFFFFFF to 0. A bus write takes priority over the increment in the same cycle.
- **Edge detect.** `seen_d` is a registered copy of `CorrelationSeen`. `rise[i] = CorrelationSeen[i] & ~seen_d[i] & mask[i] & en`.
- **Staging, per channel.** On `rise[i]`:
  - If `stage_v[i]`=0: set `stage_v[i]`, latch the current `TSTAMP` into `stage_ts[i]`, and set `PEND[i]`.
  - If `stage_v[i]`=1: drop the event and set `ovf`.
- **Arbiter.** Each cycle, the lowest-numbered channel with `stage_v` set is pushed into the FIFO, provided the FIFO is not full or a pop happens in the same cycle. Pushing clears that channel's `stage_v`. At most one push per cycle.
- **Full FIFO.** Staged entries wait; nothing is lost at this point. Loss occurs only through the re-edge case in staging.
- **Pop.** The FIFO pops on the clock edge where `read`=1, `addr`=`BASE`+0x0C and `count`>0.
  - Push and pop in the same cycle: both happen and `count` is unchanged.
  - This holds when full as well.
- **Interrupt.** `EventIrq` = `en & (count!=0 | ovf)`. It is combinational from registered state.
- **Clearing `en`.** Stops staging and the timestamp counter. Staged entries still drain into the FIFO. The FIFO contents are kept.
- **Reset.** Asynchronous reset clears everything to 0:
  - `CTRL`, `PEND`, `ovf`, `TSTAMP`.
  - FIFO pointers and count.
  - `stage_v`, `seen_d`.
  - Reset in the middle of operation discards all queued events.

## Timing
- `CorrelationSeen[i]` rises in cycle N:
  - `stage_v[i]` is set at edge N+1.
  - The FIFO push happens at edge N+2 if the arbiter grants it.
  - `EventIrq` is high from cycle N+2.
- The timestamp in the entry is the `TSTAMP` value present during cycle N.
- `Rdata` for `DATA` shows the FIFO head in the same cycle as `read`. The pointer advances at the end of that cycle.
- Edges on k channels in the same cycle reach the FIFO over k consecutive cycles, lowest channel first, all with the same timestamp.
- Register writes take effect at the next edge. A `PEND` write-1-clear and a set of the same bit in the same cycle: the set wins.
- An `ovf` clear and a new overflow in the same cycle: the overflow wins.

## Test plan
- **Reset and idle.** Drive `rst`=0, then release it; read every register. Required: all reads return 0 and `EventIrq`=0.
- **Single event.** `CTRL`=0x0000_FF01; apply 5 `PushADC` pulses; raise `CorrelationSeen[6]`. Required:
  - `EventIrq` goes high 2 cycles later.
  - `DATA` = 0xE000_0005; then `STAT`=0x100 and `EventIrq`=0.
- **Simultaneous edges.** Raise channels 0, 3 and 7 in the same cycle, with `TSTAMP`=0x20. Required:
  - `count` goes 1, 2, 3 on successive cycles.
  - Pops return 0x8000_0020, 0xB000_0020, 0xF000_0020.
- **Full FIFO.** Queue 8 events, then raise channel 2. Required:
  - Channel 2 stays staged and `ovf`=0.
  - After one pop, the channel 2 entry enters the FIFO.
  - Dropping channel 2 and raising it again while it is still staged sets `ovf`=1. Writing 0x400 to `STAT` clears it.
- **Mask and wrap.**
  - Mask = 0xFE: raising channel 0 has no effect. Channel 1 is accepted.
  - Set `TSTAMP`=0xFFFFFFF and apply one `PushADC`: `TSTAMP` reads 0.
- **Push and pop in the same cycle when full.** Required: `count` stays 8, data order is preserved, and no `ovf`.
